// File: rtl/seq_add_n.sv
// seq_add_n: multi-cycle adder/subtractor that processes CHUNK bits per clock,
// LSB chunk first, and presents a registered result with a one-cycle done pulse.
module seq_add_n #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] psum_r;
    logic             carry_r;
    logic [KW-1:0]    k_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   chunk_sum_s;
    logic             msb_cin_s;
    logic [WIDTH-1:0] psum_next_s;
    logic             last_chunk_s;
    logic             accept_s;

    // Current chunk addition and merged partial sum; carry into the chunk MSB is
    // recovered as a^b^sum at that bit, which also covers the single-bit chunk case.
    always_comb begin
        a_chunk_s   = a_r[int'(k_r) * CHUNK +: CHUNK];
        b_chunk_s   = b_r[int'(k_r) * CHUNK +: CHUNK];
        chunk_sum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
        msb_cin_s   = a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ chunk_sum_s[CHUNK-1];
        psum_next_s = psum_r;
        psum_next_s[int'(k_r) * CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
        last_chunk_s = (k_r == LAST_K);
        if (start && ((state_r == IDLE) || (state_r == DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Sequencer: accepts operations in IDLE or DONE, walks the chunks in RUN,
    // and loads the registered result on the edge entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            psum_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            k_r     <= {KW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            s_r     <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b ^ {WIDTH{sub}};
            carry_r <= sub ? 1'b1 : cin;
            k_r     <= {KW{1'b0}};
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                RUN: begin
                    carry_r <= chunk_sum_s[CHUNK];
                    psum_r  <= psum_next_s;
                    k_r     <= k_r + KW'(1);
                    if (last_chunk_s) begin
                        s_r     <= psum_next_s;
                        cout_r  <= chunk_sum_s[CHUNK];
                        ovf_r   <= msb_cin_s ^ chunk_sum_s[CHUNK];
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_seq_add_n.sv
// Scoreboard bench for seq_add_n: three configurations (16/4, 4/1, 8/8) driven
// one at a time; expected results are queued at issue and checked on done.
module tb_seq_add_n;

    logic clk;
    logic rst_n;

    logic [15:0] a0, b0, s0;
    logic        cin0, sub0, start0, busy0, done0, cout0, ovf0;
    logic [3:0]  a1, b1, s1;
    logic        cin1, sub1, start1, busy1, done1, cout1, ovf1;
    logic [7:0]  a2, b2, s2;
    logic        cin2, sub2, start2, busy2, done2, cout2, ovf2;

    seq_add_n #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
        .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0));
    seq_add_n #(.WIDTH(4), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1));
    seq_add_n #(.WIDTH(8), .CHUNK(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2));

    typedef struct {
        int          id;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        int          issue;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;
    int   cyc;

    logic [15:0] ms[3];
    logic        md[3], mb[3], mc[3], mo[3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    always_comb begin
        ms[0] = s0;            md[0] = done0; mb[0] = busy0; mc[0] = cout0; mo[0] = ovf0;
        ms[1] = {12'b0, s1};   md[1] = done1; mb[1] = busy1; mc[1] = cout1; mo[1] = ovf1;
        ms[2] = {8'b0, s2};    md[2] = done2; mb[2] = busy2; mc[2] = cout2; mo[2] = ovf2;
    end

    function automatic int nch(input int id);
        case (id)
            0:       return 4;
            1:       return 4;
            2:       return 1;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops on done, otherwise checks that outputs hold the last result.
    initial begin
        logic [15:0] hs[3];
        logic        hc[3], ho[3];
        int          bcnt[3];
        exp_t        e;
        for (int g = 0; g < 3; g++) begin
            hs[g] = 16'h0; hc[g] = 1'b0; ho[g] = 1'b0; bcnt[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (!rst_n) begin
                    hs[g] = 16'h0; hc[g] = 1'b0; ho[g] = 1'b0; bcnt[g] = 0;
                end else begin
                    if (md[g]) begin
                        if (q.size() == 0 || q[0].id != g) begin
                            chk($sformatf("unexpected_done%0d", g), 32'd1, 32'd0);
                        end else begin
                            e = q.pop_front();
                            chk($sformatf("s%0d", g), 32'(ms[g]), 32'(e.s));
                            chk($sformatf("cout%0d", g), 32'(mc[g]), 32'(e.cout));
                            chk($sformatf("ovf%0d", g), 32'(mo[g]), 32'(e.ovf));
                            chk($sformatf("latency%0d", g), 32'(cyc), 32'(e.issue + nch(g)));
                            chk($sformatf("busy_len%0d", g), 32'(bcnt[g]), 32'(nch(g)));
                            hs[g] = e.s; hc[g] = e.cout; ho[g] = e.ovf;
                        end
                    end else begin
                        chk($sformatf("hold_s%0d", g), 32'(ms[g]), 32'(hs[g]));
                        chk($sformatf("hold_cout%0d", g), 32'(mc[g]), 32'(hc[g]));
                        chk($sformatf("hold_ovf%0d", g), 32'(mo[g]), 32'(ho[g]));
                    end
                    bcnt[g] = mb[g] ? bcnt[g] + 1 : 0;
                end
            end
        end
    end

    task automatic drive(input int id, input logic st, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        case (id)
            0: begin start0 = st; a0 = a;      b0 = b;      cin0 = cin; sub0 = sub; end
            1: begin start1 = st; a1 = a[3:0]; b1 = b[3:0]; cin1 = cin; sub1 = sub; end
            2: begin start2 = st; a2 = a[7:0]; b2 = b[7:0]; cin2 = cin; sub2 = sub; end
            default: begin start0 = 1'b0; end
        endcase
    endtask

    // Called just after a negedge; issues one operation and waits for it to drain.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         input logic [15:0] es, input logic ec, input logic eo);
        drive(id, 1'b1, a, b, cin, sub);
        q.push_back('{id, es, ec, eo, cyc + 1});
        @(posedge clk);
        @(negedge clk);
        drive(id, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (nch(id) + 1) @(negedge clk);
    endtask

    function automatic void ref4(input int a, input int b, input int c, input bit sb,
                                 output logic [15:0] s, output logic co, output logic ov);
        int bb;
        int u;
        int sa;
        int sbv;
        int r;
        bb  = sb ? ((~b) & 15) : b;
        u   = a + bb + (sb ? 1 : c);
        s   = 16'(u & 15);
        co  = (u > 15);
        sa  = (a > 7) ? a - 16 : a;
        sbv = (b > 7) ? b - 16 : b;
        r   = sb ? (sa - sbv) : (sa + sbv + c);
        ov  = (r > 7) || (r < -8);
    endfunction

    initial begin
        logic [15:0] es;
        logic        ec, eo;
        int          t;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(2, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #3;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_s", 32'(s0), 32'd0);
        chk("rst_cout_ovf", 32'({cout0, ovf0}), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Directed 16/4 vectors
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue(0, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        issue(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        issue(0, 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Back-to-back with start held high; operands change to garbage during RUN
        drive(0, 1'b1, 16'h00FF, 16'h0F01, 1'b0, 1'b0);
        q.push_back('{0, 16'h1000, 1'b0, 1'b0, cyc + 1});
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1);
        end
        @(negedge clk);
        drive(0, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
        q.push_back('{0, 16'h0000, 1'b1, 1'b0, cyc + 1});
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);

        // Start pulses during RUN must be ignored
        drive(0, 1'b1, 16'h0101, 16'h0202, 1'b0, 1'b0);
        q.push_back('{0, 16'h0303, 1'b0, 1'b0, cyc + 1});
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 16'h7777, 16'h7777, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        // Reset two cycles into RUN aborts the operation
        drive(0, 1'b1, 16'h1111, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_s", 32'(s0), 32'd0);
        chk("abort_cout_ovf_done", 32'({cout0, ovf0, done0}), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        repeat (6) @(negedge clk);
        issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

        // 4/1 exhaustive against the reference model
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    ref4(x, y, c, 1'b0, es, ec, eo);
                    issue(1, 16'(x), 16'(y), c[0], 1'b0, es, ec, eo);
                end
                ref4(x, y, 0, 1'b1, es, ec, eo);
                issue(1, 16'(x), 16'(y), 1'b0, 1'b1, es, ec, eo);
            end
        end

        // 8/8 single-chunk case
        issue(2, 16'h0080, 16'h0080, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1);
        issue(2, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0);

        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
